// File: rtl/tap_sample_sequencer.sv
// Circular sample history with a sequential tap reader that feeds one shared MAC.
// Every accepted sample is followed by a burst of TAPS taps, newest first.
module tap_sample_sequencer #(
  parameter int N     = 16,
  parameter int TAPS  = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     tap_data,
  output logic [IDX_W-1:0] tap_idx,
  output logic             tap_valid,
  input  logic             tap_ready,
  output logic             tap_first,
  output logic             tap_last,
  output logic             busy
);

  localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [AW-1:0]    LAST_PTR  = AW'(TAPS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TAPS - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e           state_q;
  logic [N-1:0]     mem_q [TAPS];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [N-1:0]     tap_data_q;
  logic [IDX_W-1:0] tap_idx_q;
  logic             tap_valid_q;
  logic             tap_first_q;
  logic             tap_last_q;
  logic             in_ready_q;
  logic             busy_q;

  logic [AW-1:0]    wr_ptr_d;
  logic [AW-1:0]    rd_ptr_d;
  logic [IDX_W-1:0] tap_idx_d;

  // Pointer steps wrap explicitly so non-power-of-two depths stay correct.
  always_comb begin
    wr_ptr_d  = (wr_ptr_q == LAST_PTR) ? {AW{1'b0}} : wr_ptr_q + AW'(1);
    rd_ptr_d  = (rd_ptr_q == {AW{1'b0}}) ? LAST_PTR : rd_ptr_q - AW'(1);
    tap_idx_d = tap_idx_q + IDX_W'(1);
  end

  // Sequencer FSM: history writes, read pointer walk and registered tap outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      tap_data_q  <= {N{1'b0}};
      tap_idx_q   <= {IDX_W{1'b0}};
      tap_valid_q <= 1'b0;
      tap_first_q <= 1'b0;
      tap_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        mem_q[i] <= {N{1'b0}};
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // Tap 0 is the sample being written, so it is loaded straight into the output register.
            mem_q[wr_ptr_q] <= data_in;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= wr_ptr_q;
            tap_data_q      <= data_in;
            tap_idx_q       <= {IDX_W{1'b0}};
            tap_valid_q     <= 1'b1;
            tap_first_q     <= 1'b1;
            tap_last_q      <= 1'b0;
            in_ready_q      <= 1'b0;
            busy_q          <= 1'b1;
            state_q         <= STREAM;
          end else begin
            tap_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        STREAM: begin
          if (tap_ready) begin
            if (tap_idx_q == LAST_IDX) begin
              tap_data_q  <= {N{1'b0}};
              tap_idx_q   <= {IDX_W{1'b0}};
              tap_valid_q <= 1'b0;
              tap_first_q <= 1'b0;
              tap_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end else begin
              rd_ptr_q    <= rd_ptr_d;
              tap_data_q  <= mem_q[rd_ptr_d];
              tap_idx_q   <= tap_idx_d;
              tap_first_q <= 1'b0;
              tap_last_q  <= (tap_idx_d == LAST_IDX);
            end
          end else begin
            tap_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          tap_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign tap_data  = tap_data_q;
  assign tap_idx   = tap_idx_q;
  assign tap_valid = tap_valid_q;
  assign tap_first = tap_first_q;
  assign tap_last  = tap_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tap_sample_sequencer.sv
// Bench for tap_sample_sequencer: a TAPS=4 instance driven from a vector table
// with a tap scoreboard, and a TAPS=5 instance for wrap and mid-stream reset.
module tb_tap_sample_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // TAPS=4 instance
  logic        a_rst, a_vin, a_rdy, a_tv, a_tr, a_tf, a_tl, a_busy;
  logic [15:0] a_din, a_td;
  logic [2:0]  a_ti;

  // TAPS=5 instance
  logic        b_rst, b_vin, b_rdy, b_tv, b_tr, b_tf, b_tl, b_busy;
  logic [15:0] b_din, b_td;
  logic [2:0]  b_ti;

  tap_sample_sequencer #(.N(16), .TAPS(4), .IDX_W(3)) u_a (
    .clk(clk), .reset(a_rst), .data_in(a_din), .in_valid(a_vin), .in_ready(a_rdy),
    .tap_data(a_td), .tap_idx(a_ti), .tap_valid(a_tv), .tap_ready(a_tr),
    .tap_first(a_tf), .tap_last(a_tl), .busy(a_busy)
  );

  tap_sample_sequencer #(.N(16), .TAPS(5), .IDX_W(3)) u_b (
    .clk(clk), .reset(b_rst), .data_in(b_din), .in_valid(b_vin), .in_ready(b_rdy),
    .tap_data(b_td), .tap_idx(b_ti), .tap_valid(b_tv), .tap_ready(b_tr),
    .tap_first(b_tf), .tap_last(b_tl), .busy(b_busy)
  );

  typedef struct {
    logic [15:0] data;
    logic [2:0]  idx;
    logic        first;
    logic        last;
  } tap_t;

  typedef struct {
    logic [15:0]       din;
    int                stall_idx;
    int                stall_n;
    logic              hold;
    logic [15:0]       nxt;
    logic [0:3][15:0]  exp;
  } vec_t;

  tap_t sb_q[$];
  tap_t mon_e;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] din, input int si, input int sn,
                              input logic hold, input logic [15:0] nxt,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
    vec_t v;
    v.din = din; v.stall_idx = si; v.stall_n = sn; v.hold = hold; v.nxt = nxt;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  // Scoreboard: every tap handshake on instance A pops one expected tap.
  always @(negedge clk) begin
    #3;
    if (a_tv === 1'b1 && a_tr === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_unexpected_tap: got idx %0d data 0x%0h, want no tap", a_ti, a_td);
      end else begin
        mon_e = sb_q.pop_front();
        chk("a_tap_data", a_td, mon_e.data);
        chk("a_tap_idx_sb", a_ti, mon_e.idx);
        chk("a_tap_first", a_tf, mon_e.first);
        chk("a_tap_last", a_tl, mon_e.last);
      end
    end
  end

  task automatic burst_a(input vec_t v);
    int w, c, k, stalls;
    logic [15:0] cap_d;
    logic        cap_l;
    tap_t        t;
    w = 0;
    while (a_rdy !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("a_in_ready_before", a_rdy, 1);
    a_din = v.din;
    a_vin = 1'b1;
    a_tr  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      t.data = v.exp[j]; t.idx = 3'(j); t.first = (j == 0); t.last = (j == 3);
      sb_q.push_back(t);
    end
    c = 0; k = 0; stalls = 0; cap_d = 16'd0; cap_l = 1'b0;
    while (k < 4 && c < 40) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        a_vin = v.hold;
        a_din = v.hold ? v.nxt : 16'd0;
        chk("a_first_latency", {a_tv, a_ti}, {1'b1, 3'd0});
      end
      chk("a_tap_valid", a_tv, 1);
      chk("a_in_ready_stream", a_rdy, 0);
      chk("a_busy_stream", a_busy, 1);
      chk("a_tap_idx", a_ti, k);
      if (k == v.stall_idx && stalls > 0) begin
        chk("a_stall_data", a_td, cap_d);
        chk("a_stall_last", a_tl, cap_l);
      end
      if (k == v.stall_idx && stalls < v.stall_n) begin
        if (stalls == 0) begin
          cap_d = a_td;
          cap_l = a_tl;
        end
        a_tr = 1'b0;
        stalls++;
      end else begin
        a_tr = 1'b1;
        k++;
      end
    end
    chk("a_burst_len", c, 4 + v.stall_n);
    @(negedge clk);
    chk("a_in_ready_after", a_rdy, 1);
    chk("a_tap_valid_after", a_tv, 0);
    chk("a_busy_after", a_busy, 0);
    if (!v.hold) a_vin = 1'b0;
  endtask

  task automatic burst_b(input logic [15:0] val, input logic [15:0] lo, input int abort_idx);
    int w, e;
    w = 0;
    while (b_rdy !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("b_in_ready_before", b_rdy, 1);
    b_din = val;
    b_vin = 1'b1;
    b_tr  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) b_vin = 1'b0;
      e = (int'(val) - k >= int'(lo)) ? int'(val) - k : 0;
      chk("b_tap_valid", b_tv, 1);
      chk("b_tap_idx", b_ti, k);
      chk("b_tap_data", b_td, e);
      chk("b_tap_first", b_tf, (k == 0));
      chk("b_tap_last", b_tl, (k == 4));
      if (k == abort_idx) begin
        b_rst = 1'b1;
        #1;
        chk("b_abort_valid", b_tv, 0);
        chk("b_abort_busy", b_busy, 0);
        chk("b_abort_ready", b_rdy, 1);
        chk("b_abort_data", b_td, 0);
        @(negedge clk);
        b_rst = 1'b0;
        chk("b_abort_idle", b_tv, 0);
        return;
      end
    end
    @(negedge clk);
    chk("b_in_ready_after", b_rdy, 1);
    chk("b_tap_valid_after", b_tv, 0);
  endtask

  initial begin
    a_rst = 1'b1; a_vin = 1'b0; a_din = 16'd0; a_tr = 1'b1;
    b_rst = 1'b1; b_vin = 1'b0; b_din = 16'd0; b_tr = 1'b1;

    vecs[0] = mk(16'd5, -1, 0, 1'b0, 16'd0, 16'd5, 16'd0, 16'd0, 16'd0);
    vecs[1] = mk(16'd1, -1, 0, 1'b0, 16'd0, 16'd1, 16'd5, 16'd0, 16'd0);
    vecs[2] = mk(16'd2, -1, 0, 1'b0, 16'd0, 16'd2, 16'd1, 16'd5, 16'd0);
    vecs[3] = mk(16'd3, -1, 0, 1'b0, 16'd0, 16'd3, 16'd2, 16'd1, 16'd5);
    vecs[4] = mk(16'd4, -1, 0, 1'b0, 16'd0, 16'd4, 16'd3, 16'd2, 16'd1);
    vecs[5] = mk(16'd5, -1, 0, 1'b0, 16'd0, 16'd5, 16'd4, 16'd3, 16'd2);
    vecs[6] = mk(16'd6,  2, 3, 1'b0, 16'd0, 16'd6, 16'd5, 16'd4, 16'd3);
    vecs[7] = mk(16'd7, -1, 0, 1'b1, 16'd9, 16'd7, 16'd6, 16'd5, 16'd4);
    vecs[8] = mk(16'd9, -1, 0, 1'b0, 16'd0, 16'd9, 16'd7, 16'd6, 16'd5);
    vecs[9] = mk(16'd8,  3, 2, 1'b0, 16'd0, 16'd8, 16'd9, 16'd7, 16'd6);

    repeat (3) @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", a_rdy, 1);
    chk("rst_tap_valid", a_tv, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_tap_idx", a_ti, 0);
    chk("rst_tap_data", a_td, 0);
    chk("rst_tap_first", a_tf, 0);
    chk("rst_tap_last", a_tl, 0);
    chk("rst_b_in_ready", b_rdy, 1);
    repeat (3) @(negedge clk);
    chk("rst_idle_no_tap", a_tv, 0);

    for (int i = 0; i < 10; i++) begin
      burst_a(vecs[i]);
    end
    @(negedge clk);
    #4;
    chk("a_scoreboard_empty", sb_q.size(), 0);

    for (int v = 10; v <= 16; v++) begin
      burst_b(16'(v), 16'd10, -1);
    end
    burst_b(16'd17, 16'd10, 2);
    burst_b(16'd7, 16'd7, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tap_sample_sequencer.md
Name: tap_sample_sequencer

Overview:
Sample history buffer and tap reader for a time-multiplexed FIR datapath. It accepts one input sample per handshake and stores the last TAPS samples in a circular buffer. After each accepted sample it streams the stored history out one tap per cycle, newest first, to a single shared MAC. It is the read side of the tap delay line: the per-tap register chain is replaced by one buffer plus a sequential reader.

Parameters:
N, 16, sample width in bits
TAPS, 8, history depth and taps emitted per input sample; must be >= 2, need not be a power of two
IDX_W, 3, tap index width; must be >= clog2(TAPS)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  N  input sample
in_valid  input  1  data_in valid
in_ready  output  1  block can accept a sample this cycle
tap_data  output  N  history sample for the current tap
tap_idx  output  IDX_W  tap number, 0 = newest sample
tap_valid  output  1  tap_data/tap_idx valid
tap_ready  input  1  downstream MAC accepts the current tap
tap_first  output  1  high with tap_idx == 0
tap_last  output  1  high with tap_idx == TAPS-1
busy  output  1  high while in STREAM

Behaviour:
- Reset (async, active-high) forces:
  - in_ready=1, tap_valid=0, tap_idx=0, tap_first=0, tap_last=0, busy=0, tap_data=0;
  - all TAPS buffer entries = 0, write pointer = 0, state IDLE.
- States: IDLE, STREAM.
- IDLE:
  - in_ready=1, tap_valid=0.
  - When in_valid=1, data_in is written at the write pointer at the clock edge.
  - The write pointer advances with wrap from TAPS-1 to 0.
  - Tap counter k is set to 0 and the state moves to STREAM.
- STREAM:
  - in_ready=0 and busy=1; in_valid is ignored and no write occurs.
  - tap_valid=1, tap_idx=k.
  - tap_data = entry at (last written position - k) mod TAPS, with explicit wrap handling, so it is correct for non-power-of-two TAPS.
  - tap_first=(k==0), tap_last=(k==TAPS-1).
  - When tap_valid && tap_ready: if k < TAPS-1, k increments; if k == TAPS-1, return to IDLE.
  - When tap_ready=0, every tap_* output holds stable.
- Latency:
  - Sample accepted at edge t; tap 0 (that same sample) is valid in cycle t+1.
  - With tap_ready held high, the last tap is presented in cycle t+TAPS.
  - in_ready returns in cycle t+TAPS+1, giving one sample per TAPS+1 cycles.
- History: entries never written since reset read as 0, so early samples behave as zero-padded history.
- No arithmetic is performed on samples; data is passed bit-exact (signedness is irrelevant here).
- Reset mid-stream: aborts immediately. No further tap_valid is produced and the history is cleared to 0.
- Simultaneous in_valid with the final tap handshake: the sample is not accepted in that cycle (in_ready=0). It is accepted in the following IDLE cycle if still presented.
- tap_data is driven from registered pointers and buffer contents. There is no combinational path from data_in or in_valid to any output.

Test Plan:
- Reset: assert reset, then release with in_valid=0 -> in_ready=1, tap_valid=0, busy=0, all outputs 0, no tap traffic.
- First sample, TAPS=4, tap_ready=1: accept 5 after reset -> taps 5,0,0,0 on four consecutive cycles with idx 0..3. tap_first only on idx 0, tap_last only on idx 3. in_ready=1 on the following cycle.
- Steady history, TAPS=4: feed 1,2,3,4,5 back-to-back as in_ready allows -> after the 5th sample taps are 5,4,3,2. Each burst starts exactly 1 cycle after acceptance; the sample period is 5 cycles.
- Backpressure, TAPS=4: hold tap_ready=0 for 3 cycles at idx 2 -> tap_data/tap_idx/tap_last stable throughout. The burst completes idx 3 after release; total burst length = 4 + 3 stall cycles.
- Input blocked during STREAM: drive in_valid=1 with data 9 throughout a burst -> 9 is not written mid-burst. It is accepted on the first IDLE cycle and the next burst starts with 9.
- Wrap, TAPS=5, and reset mid-stream:
  - feed 10..16 -> after 16 the taps are 16,15,14,13,12;
  - assert reset at idx 2 -> tap_valid=0 at once;
  - next sample 7 -> taps 7,0,0,0,0.
